// File: rtl/tree_accum_pkg.sv
// Shared types and default widths for the tree accumulator controller.
// The ACC_SAT_EN build option is handled in tree_accum_ctrl.
package tree_accum_pkg;

    localparam int LANES         = 8;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_ACC_WIDTH = 24;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/tree_accum_ctrl_treeadder.sv
// Combinational 8-input adder tree; every level wraps modulo 2^WIDTH.
// Lane i is in_data[i*WIDTH +: WIDTH].
module treeadder
    import tree_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]       sum
);

    logic [WIDTH-1:0] lvl1 [4];
    logic [WIDTH-1:0] lvl2 [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = in_data[(2*i)*WIDTH +: WIDTH]
                    + in_data[(2*i+1)*WIDTH +: WIDTH];
        end
        for (int j = 0; j < 2; j++) begin
            lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
        end
        sum = lvl2[0] + lvl2[1];
    end

endmodule

// File: rtl/tree_accum_ctrl.sv
// Streams cfg_beats x 8-lane beats through treeadder and accumulates the sums.
// Define ACC_SAT_EN for a saturating accumulator with a sticky ovf flag.
module tree_accum_ctrl
    import tree_accum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       cfg_beats,
    output logic                   busy,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   ovf
);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     remaining;
    logic [WIDTH-1:0]     tree_sum;
    logic [WIDTH-1:0]     pipe_sum;
    logic                 pipe_vld;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_upd;
    logic [ACC_WIDTH-1:0] sum_sx;
    logic                 hs;
    logic                 job_go;

    treeadder #(.WIDTH(WIDTH)) u_tree (
        .in_data (in_data),
        .sum     (tree_sum)
    );

    assign in_ready  = (state == RUN);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign hs        = in_valid && in_ready;
    assign job_go    = (state == IDLE) && start;
    assign sum_sx    = {{(ACC_WIDTH-WIDTH){pipe_sum[WIDTH-1]}}, pipe_sum};

`ifdef ACC_SAT_EN
    logic                 ovf_q;
    logic                 clamp;
    logic [ACC_WIDTH:0]   sum_ext;

    // One guard bit exposes signed overflow of the accumulate.
    assign sum_ext = {acc[ACC_WIDTH-1], acc} + {sum_sx[ACC_WIDTH-1], sum_sx};
    assign clamp   = sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1];

    always_comb begin
        acc_upd = sum_ext[ACC_WIDTH-1:0];
        if (clamp) begin
            acc_upd = {sum_ext[ACC_WIDTH], {(ACC_WIDTH-1){~sum_ext[ACC_WIDTH]}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (job_go) begin
            ovf_q <= 1'b0;
        end else if (pipe_vld && clamp) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_upd = acc + sum_sx;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (cfg_beats != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (hs && remaining == CNT_W'(1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_vld) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            pipe_sum  <= '0;
            pipe_vld  <= 1'b0;
            remaining <= '0;
        end else begin
            pipe_vld <= hs;
            if (hs) begin
                pipe_sum  <= tree_sum;
                remaining <= remaining - CNT_W'(1);
            end
            if (job_go) begin
                acc       <= '0;
                remaining <= cfg_beats;
            end else if (pipe_vld) begin
                acc <= acc_upd;
            end
        end
    end

endmodule

// File: tb/tb_tree_accum_ctrl.sv
// Scoreboard bench for tree_accum_ctrl: default-width DUT plus a 16-bit-acc DUT.
// Expected totals follow ACC_SAT_EN when the bench is built with it.
module tb_tree_accum_ctrl;
    import tree_accum_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [7:0]   cfg_beats;
    logic [127:0] in_data;
    logic         in_valid, out_ready;

    logic         busy_a, rdy_a, ov_a, ovf_a;
    logic [23:0]  od_a;
    logic         busy_b, rdy_b, ov_b, ovf_b;
    logic [15:0]  od_b;

    bit           sel;
    logic         busy, rdy, ov, ovf;
    logic [23:0]  od;

    logic [127:0] beats_q[$];
    logic [23:0]  exp_q[$];
    bit           eovf_q[$];
    int           nvec = 0;
    int           nerr = 0;

    always #5 clk = ~clk;

    tree_accum_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cfg_beats(cfg_beats),
        .busy(busy_a), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .out_data(od_a), .out_valid(ov_a),
        .out_ready(out_ready), .ovf(ovf_a)
    );

    tree_accum_ctrl #(.ACC_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cfg_beats(cfg_beats),
        .busy(busy_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b),
        .out_ready(out_ready), .ovf(ovf_b)
    );

    assign busy = sel ? busy_b : busy_a;
    assign rdy  = sel ? rdy_b  : rdy_a;
    assign ov   = sel ? ov_b   : ov_a;
    assign ovf  = sel ? ovf_b  : ovf_a;
    assign od   = sel ? {8'h00, od_b} : od_a;

    function automatic logic [127:0] mk(input int base, input int step);
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(base + i*step);
        return v;
    endfunction

    function automatic void model(input int aw, input int nb,
                                  output logic [23:0] res, output bit o);
        longint acc, lo, hi;
        int t;
        acc = 0;
        o = 1'b0;
        lo = -(longint'(1) << (aw-1));
        hi = (longint'(1) << (aw-1)) - 1;
        for (int b = 0; b < nb; b++) begin
            t = 0;
            for (int l = 0; l < 8; l++) t += int'(beats_q[b][l*16 +: 16]);
            t = t & 32'hFFFF;
            if (t >= 32768) t -= 65536;
            acc += t;
`ifdef ACC_SAT_EN
            if (acc > hi) begin acc = hi; o = 1'b1; end
            else if (acc < lo) begin acc = lo; o = 1'b1; end
`else
            if (lo > hi) o = 1'b1;
`endif
        end
        res = 24'(acc) & 24'((longint'(1) << aw) - 1);
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else start_a = v;
    endtask

    task automatic run_job(input int nb, input bit tog, input int hold, input bit poke);
        logic [23:0] er, held, got;
        bit eo, go;
        int consumed, cyc;
        bit hs;
        model(sel ? 16 : 24, nb, er, eo);
        exp_q.push_back(er);
        eovf_q.push_back(eo);
        cfg_beats = 8'(nb);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        cfg_beats = 8'h55;
        if (nb == 0) begin
            in_valid = 1'b1;
            nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL zero_rdy got %b want 0", rdy); end
            nvec++; if (ov !== 1'b1) begin nerr++; $display("FAIL zero_ov got %b want 1", ov); end
            in_valid = 1'b0;
        end else begin
            consumed = 0;
            cyc = 0;
            while (consumed < nb && cyc < 200) begin
                in_valid = tog ? ((cyc % 2) == 0) : 1'b1;
                in_data = in_valid ? beats_q[consumed] : {$urandom, $urandom, $urandom, $urandom};
                if (poke && cyc == 1) begin cfg_beats = 8'd9; set_start(1'b1); end
                hs = in_valid && rdy;
                @(negedge clk);
                set_start(1'b0);
                cyc++;
                if (hs) consumed++;
            end
            in_valid = 1'b0;
            nvec++; if (consumed != nb) begin nerr++; $display("FAIL beats got %0d want %0d", consumed, nb); end
            nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL drain_rdy got %b want 0", rdy); end
            nvec++; if (ov !== 1'b0) begin nerr++; $display("FAIL drain_ov got %b want 0", ov); end
            in_valid = 1'b1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            in_valid = 1'b0;
            nvec++; if (ov !== 1'b1) begin nerr++; $display("FAIL latency got %b want 1", ov); end
        end
        held = od;
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 0) set_start(1'b1);
            @(negedge clk);
            set_start(1'b0);
            nvec++;
            if (ov !== 1'b1 || od !== held) begin
                nerr++; $display("FAIL hold got %b/%h want 1/%h", ov, od, held);
            end
        end
        if (ov === 1'b1) begin
            er = exp_q.pop_front();
            eo = eovf_q.pop_front();
            got = od;
            go = ovf;
            nvec++; if (got !== er) begin nerr++; $display("FAIL result got %h want %h", got, er); end
            nvec++; if (go !== eo) begin nerr++; $display("FAIL ovf got %b want %b", go, eo); end
        end
        out_ready = 1'b1;
        set_start(poke);
        @(negedge clk);
        out_ready = 1'b0;
        set_start(1'b0);
        nvec++; if (ov !== 1'b0) begin nerr++; $display("FAIL accept_ov got %b want 0", ov); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL accept_busy got %b want 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 0; start_b = 0; cfg_beats = 0;
        in_data = '0; in_valid = 0; out_ready = 0; sel = 0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy_a, rdy_a, ov_a, ovf_a, busy_b, rdy_b, ov_b, ovf_b} !== 8'h00) begin
            nerr++; $display("FAIL reset_ctl got %b want 0", {busy_a, rdy_a, ov_a, ovf_a, busy_b, rdy_b, ov_b, ovf_b});
        end
        nvec++;
        if (od_a !== 24'h0 || od_b !== 16'h0) begin
            nerr++; $display("FAIL reset_data got %h/%h want 0", od_a, od_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        cfg_beats = 8'd4;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = mk(100 + i, 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy got %b want 0", busy); end
        nvec++; if (rdy !== 1'b0) begin nerr++; $display("FAIL mid_rdy got %b want 0", rdy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if (ov !== 1'b0) begin nerr++; $display("FAIL mid_ov got %b want 0", ov); end
        end
        beats_q = {};
        beats_q.push_back(mk(1, 0));
        run_job(1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_single();
        sel = 0;
        beats_q = {};
        beats_q.push_back(mk(1, 1));
        run_job(1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_toggle();
        sel = 0;
        beats_q = {};
        repeat (4) beats_q.push_back(mk(-1, 0));
        run_job(4, 1'b1, 0, 1'b0);
    endtask

    task automatic test_zero();
        sel = 0;
        beats_q = {};
        run_job(0, 1'b0, 5, 1'b0);
    endtask

    task automatic test_sat();
        sel = 1;
        beats_q = {};
        repeat (3) beats_q.push_back(mk(16'h0FFF, 0));
        run_job(3, 1'b0, 0, 1'b0);
        sel = 0;
    endtask

    task automatic test_start_ignored();
        sel = 0;
        beats_q = {};
        repeat (3) beats_q.push_back({$urandom, $urandom, $urandom, $urandom});
        run_job(3, 1'b0, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        beats_q = {};
        repeat (5) beats_q.push_back({$urandom, $urandom, $urandom, $urandom});
        run_job(5, 1'b1, 0, 1'b0);
        beats_q = {};
        repeat (2) beats_q.push_back({$urandom, $urandom, $urandom, $urandom});
        run_job(2, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_toggle();
        test_zero();
        test_sat();
        test_start_ignored();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL missing_results got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
